// File: rtl/pz_pkg.sv
// Shared types and helpers for the pole/zero accumulation blocks.
// Holds the FSM state encoding and a constant-foldable clog2 used for port widths.
package pz_pkg;

  typedef enum logic [1:0] {
    PZ_IDLE = 2'd0,
    PZ_RUN  = 2'd1,
    PZ_DONE = 2'd2
  } pz_state_t;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int pz_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pz_saturate.sv
// Narrows a signed value to OUT_W bits, either clamping to the signed range
// or keeping the low bits (modulo wrap). Purely combinational; assumes IN_W > OUT_W.
module pz_saturate #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  value,
  input  logic                    sat_en,
  output logic signed [OUT_W-1:0] result
);

  localparam logic signed [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] upper_bits;
  logic                overflow;

  // The value fits iff every bit from the output sign bit upward agrees.
  assign upper_bits = value[IN_W-1:OUT_W-1];
  assign overflow   = !((&upper_bits) || !(|upper_bits));

  always_comb begin
    result = value[OUT_W-1:0];
    if (sat_en && overflow) begin
      result = value[IN_W-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/pz_seq_accumulator.sv
// Sequential pole/zero accumulator: result = sum(zero terms) - sum(pole terms),
// one term per clock, with start/valid/busy handshake, saturate/wrap and a count error flag.
module pz_seq_accumulator
  import pz_pkg::*;
#(
  parameter int REG_FILE_SIZE = 8,
  parameter int DATA_SIZE     = 16,
  parameter int IDX_W         = pz_clog2(REG_FILE_SIZE + 1),
  parameter int ACC_W         = DATA_SIZE + pz_clog2(REG_FILE_SIZE) + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
  input  logic [IDX_W-1:0]                   no_z,
  input  logic [IDX_W-1:0]                   no_p,
  input  logic                               sat_en,
  output logic [DATA_SIZE-1:0]               acc_pz,
  output logic                               valid,
  output logic                               busy,
  output logic                               err
);

  localparam int TERM_SLOTS = 1 << IDX_W;

  pz_state_t state_reg, state_next;

  logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_reg, flat_next;
  logic [IDX_W-1:0]                   no_z_reg, no_z_next;
  logic [IDX_W-1:0]                   no_p_reg, no_p_next;
  logic [IDX_W-1:0]                   idx_reg, idx_next;
  logic                               sat_reg, sat_next;
  logic signed [ACC_W-1:0]            acc_reg, acc_next;
  logic [DATA_SIZE-1:0]               acc_pz_reg, acc_pz_next;
  logic                               valid_reg, valid_next;
  logic                               busy_reg, busy_next;
  logic                               err_reg, err_next;

  logic [IDX_W:0]                     n_in;
  logic [IDX_W:0]                     n_cap;
  logic                               last_term;
  logic signed [DATA_SIZE-1:0]        terms [TERM_SLOTS];
  logic signed [DATA_SIZE-1:0]        term_cur;
  logic signed [ACC_W-1:0]            term_ext;
  logic signed [ACC_W-1:0]            acc_step;
  logic signed [DATA_SIZE-1:0]        sat_out;

  // Padding the term table to a power of two keeps idx_reg a full-width index.
  generate
    for (genvar gi = 0; gi < TERM_SLOTS; gi++) begin : g_terms
      if (gi < REG_FILE_SIZE) begin : g_live
        assign terms[gi] = flat_reg[DATA_SIZE*gi +: DATA_SIZE];
      end else begin : g_pad
        assign terms[gi] = '0;
      end
    end
  endgenerate

  assign n_in      = {1'b0, no_z} + {1'b0, no_p};
  assign n_cap     = {1'b0, no_z_reg} + {1'b0, no_p_reg};
  assign last_term = ({1'b0, idx_reg} == (n_cap - (IDX_W+1)'(1)));
  assign term_cur  = terms[idx_reg];
  assign term_ext  = {{(ACC_W-DATA_SIZE){term_cur[DATA_SIZE-1]}}, term_cur};
  assign acc_step  = (idx_reg < no_z_reg) ? (acc_reg + term_ext) : (acc_reg - term_ext);

  // Saturation acts on the sum including the final term, so the result lands with DONE.
  pz_saturate #(
    .IN_W (ACC_W),
    .OUT_W(DATA_SIZE)
  ) u_saturate (
    .value (acc_step),
    .sat_en(sat_reg),
    .result(sat_out)
  );

  always_comb begin
    state_next  = state_reg;
    flat_next   = flat_reg;
    no_z_next   = no_z_reg;
    no_p_next   = no_p_reg;
    idx_next    = idx_reg;
    sat_next    = sat_reg;
    acc_next    = acc_reg;
    acc_pz_next = acc_pz_reg;
    valid_next  = 1'b0;
    err_next    = err_reg;
    case (state_reg)
      PZ_IDLE: begin
        if (start) begin
          flat_next = flat_pz;
          no_z_next = no_z;
          no_p_next = no_p;
          sat_next  = sat_en;
          acc_next  = '0;
          idx_next  = '0;
          if (n_in > (IDX_W+1)'(REG_FILE_SIZE)) begin
            state_next = PZ_DONE;
            valid_next = 1'b1;
            err_next   = 1'b1;
          end else if (n_in == '0) begin
            state_next  = PZ_DONE;
            valid_next  = 1'b1;
            err_next    = 1'b0;
            acc_pz_next = '0;
          end else begin
            state_next = PZ_RUN;
          end
        end
      end
      PZ_RUN: begin
        acc_next = acc_step;
        idx_next = idx_reg + 1'b1;
        if (last_term) begin
          state_next  = PZ_DONE;
          valid_next  = 1'b1;
          err_next    = 1'b0;
          acc_pz_next = sat_out;
        end
      end
      PZ_DONE: begin
        state_next = PZ_IDLE;
      end
      default: begin
        state_next = PZ_IDLE;
      end
    endcase
    busy_next = (state_next != PZ_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= PZ_IDLE;
      flat_reg   <= '0;
      no_z_reg   <= '0;
      no_p_reg   <= '0;
      idx_reg    <= '0;
      sat_reg    <= 1'b0;
      acc_reg    <= '0;
      acc_pz_reg <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      flat_reg   <= flat_next;
      no_z_reg   <= no_z_next;
      no_p_reg   <= no_p_next;
      idx_reg    <= idx_next;
      sat_reg    <= sat_next;
      acc_reg    <= acc_next;
      acc_pz_reg <= acc_pz_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
    end
  end

  assign acc_pz = acc_pz_reg;
  assign valid  = valid_reg;
  assign busy   = busy_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_pz_seq_accumulator.sv
// Scoreboard bench for pz_seq_accumulator: stimulus pushes hand-computed results,
// a monitor pops and compares on every valid pulse (value, err flag, arrival cycle).
module tb_pz_seq_accumulator;

  localparam int RFS = 8;
  localparam int DW  = 16;
  localparam int IW  = 4;

  typedef struct {
    logic [DW-1:0] acc;
    logic          err;
    int            cyc;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [DW*RFS-1:0]   flat_pz;
  logic [IW-1:0]       no_z;
  logic [IW-1:0]       no_p;
  logic                sat_en;
  logic [DW-1:0]       acc_pz;
  logic                valid;
  logic                busy;
  logic                err;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  pz_seq_accumulator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flat_pz(flat_pz),
    .no_z   (no_z),
    .no_p   (no_p),
    .sat_en (sat_en),
    .acc_pz (acc_pz),
    .valid  (valid),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW*RFS-1:0] terms3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
    logic [DW*RFS-1:0] f;
    f = '0;
    f[DW*0 +: DW] = a;
    f[DW*1 +: DW] = b;
    f[DW*2 +: DW] = c;
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one operation from an idle DUT and waits for it to drain.
  task automatic run_op(input string name, input logic [DW*RFS-1:0] f, input int nz, input int np,
                        input logic s, input logic [DW-1:0] exp_acc, input logic exp_err);
    exp_t e;
    int   lat;
    int   bcount;
    int   guard;
    lat   = (exp_err || (nz + np) == 0) ? 0 : (nz + np);
    flat_pz = f;
    no_z    = IW'(nz);
    no_p    = IW'(np);
    sat_en  = s;
    start   = 1'b1;
    e.acc = exp_acc;
    e.err = exp_err;
    e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    flat_pz = ~f;
    bcount  = 0;
    guard   = 0;
    while (busy && guard < 50) begin
      bcount++;
      guard++;
      @(negedge clk);
    end
    chk({name, "_timeout"}, (guard < 50) ? 1 : 0, 1);
    chk({name, "_busy_cycles"}, bcount, lat + 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flat_pz  = '0;
    no_z     = '0;
    no_p     = '0;
    sat_en   = 1'b0;

    fork
      forever begin : monitor
        @(negedge clk);
        if (rst_n && valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn cyc=%0d acc_pz=0x%04h err=%0b (expect 0x%04h err=%0b cyc=%0d)",
                     cyc, acc_pz, err, e.acc, e.err, e.cyc);
            chk("acc_pz", int'(acc_pz), int'(e.acc));
            chk("err", int'(err), int'(e.err));
            chk("valid_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_acc_pz", int'(acc_pz), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", terms3(16'd100, 16'd50, 16'd30), 2, 1, 1'b0, 16'h0078, 1'b0);
    run_op("pos_sat", terms3(16'h7000, 16'h7000, 16'h7000), 3, 0, 1'b1, 16'h7FFF, 1'b0);
    run_op("pos_wrap", terms3(16'h7000, 16'h7000, 16'h7000), 3, 0, 1'b0, 16'h5000, 1'b0);
    run_op("neg_sat", terms3(16'h7000, 16'h7000, 16'h0), 0, 2, 1'b1, 16'h8000, 1'b0);
    run_op("neg_wrap", terms3(16'h7000, 16'h7000, 16'h0), 0, 2, 1'b0, 16'h2000, 1'b0);
    run_op("mixed_sign", terms3(-16'sd5, -16'sd7, 16'h0), 1, 1, 1'b1, 16'h0002, 1'b0);
    run_op("empty", terms3(16'd9, 16'd9, 16'd9), 0, 0, 1'b1, 16'h0000, 1'b0);
    run_op("range_err", terms3(16'd9, 16'd9, 16'd9), 5, 4, 1'b0, 16'h0000, 1'b1);

    // start held high: accepts every 4 cycles, each using operands captured at its accept edge
    begin
      exp_t e;
      int   c;
      c       = cyc + 1;
      flat_pz = terms3(16'd10, 16'd3, 16'd0);
      no_z    = 4'd1;
      no_p    = 4'd1;
      sat_en  = 1'b0;
      start   = 1'b1;
      e.err = 1'b0;
      e.acc = 16'd7;    e.cyc = c + 2;  exp_q.push_back(e);
      e.acc = 16'd15;   e.cyc = c + 6;  exp_q.push_back(e);
      e.acc = 16'hFFFF; e.cyc = c + 10; exp_q.push_back(e);
      @(negedge clk);
      flat_pz = terms3(16'd20, 16'd5, 16'd0);
      repeat (5) @(negedge clk);
      flat_pz = terms3(16'd1, 16'd2, 16'd0);
      repeat (6) @(negedge clk);
      start = 1'b0;
      guard = 0;
      while ((busy || exp_q.size() != 0) && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      chk("b2b_drained", exp_q.size(), 0);
    end

    // Reset in the second RUN cycle of an 8-term operation aborts it silently
    flat_pz = {8{16'h0001}};
    no_z    = 4'd8;
    no_p    = 4'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_acc_pz", int'(acc_pz), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    run_op("after_reset", terms3(16'd1, 16'd1, 16'd1), 3, 0, 1'b0, 16'h0003, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pz_seq_accumulator.md
Name: pz_seq_accumulator

Overview:
- Sequential, handshaked successor to the combinational pole/zero sum: computes (sum of zero terms) minus (sum of pole terms) over a flattened register file.
- Processes one term per clock, so the design scales to large REG_FILE_SIZE without a wide adder tree.
- Adds signed arithmetic, selectable saturate/wrap output, a range-error flag and start/valid/busy handshaking.
- Sits between the pole/zero register file and the downstream phase/gain evaluation logic.

Parameters:
- REG_FILE_SIZE, 8, number of DATA_SIZE entries in flat_pz; must be >= 1.
- DATA_SIZE, 16, width of each term and of acc_pz; two's-complement signed.
- IDX_W, $clog2(REG_FILE_SIZE+1), width of no_z and no_p.
- ACC_W, DATA_SIZE+$clog2(REG_FILE_SIZE)+1, width of the internal signed accumulator. It is wide enough that no intermediate sum ever overflows.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- flat_pz  in  DATA_SIZE*REG_FILE_SIZE  term i at [DATA_SIZE*i +: DATA_SIZE]; zeros occupy the low indices, poles follow
- no_z  in  IDX_W  number of zero terms
- no_p  in  IDX_W  number of pole terms
- sat_en  in  1  1 = saturate result to DATA_SIZE signed range; 0 = wrap (truncate modulo 2^DATA_SIZE)
- acc_pz  out  DATA_SIZE  result; holds its value between completions
- valid  out  1  one-cycle pulse marking a completed operation
- busy  out  1  high whenever state != IDLE
- err  out  1  qualified by valid; indicates a count range error

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; acc_pz=0, valid=0, busy=0, err=0.
  - Internal accumulator, index and captured operands cleared.
  - Reset asserted mid-operation aborts the operation; no valid is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at a rising edge:
  - Capture flat_pz, no_z, no_p and sat_en into internal registers. Later input changes have no effect on the operation in flight.
  - Clear the accumulator; set the index to 0.
  - Let N = no_z + no_p, computed at IDX_W+1 bits.
  - If N > REG_FILE_SIZE: go to DONE with err_next=1.
  - Else if N = 0: go to DONE with result 0.
  - Else: go to RUN.
- RUN, one term per edge:
  - Sign-extend term[idx] to ACC_W.
  - If idx < no_z, add the term; otherwise subtract it.
  - Increment idx. When idx reaches N-1 on this edge, go to DONE.
- DONE (lasts one cycle): valid=1 and busy=1.
  - If err=0, acc_pz = final accumulator value, clamped to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] when the captured sat_en=1, otherwise the low DATA_SIZE bits.
  - If err=1, acc_pz keeps its previous value.
  - Next edge returns to IDLE with valid=0. err stays at its last value until the next DONE.
- Latency: valid is high in the cycle after N+1 rising edges counted from, and including, the edge that accepted start. N=0 and the error case take 1 edge.
- start while busy (RUN or DONE) is ignored and not queued. start in the IDLE cycle right after DONE is accepted normally, giving a throughput of N+2 cycles per operation.
- acc_pz, valid, busy and err are all registered outputs; no combinational input-to-output path.

Decomposition:
- Shared package pz_pkg:
  - State encoding constants PZ_IDLE=2'd0, PZ_RUN=2'd1, PZ_DONE=2'd2.
  - A clog2 helper function for IDX_W and ACC_W, reused by the existing pole/zero blocks.
- Sub-module pz_saturate: combinational, parameters IN_W and OUT_W, inputs value and sat_en, output clamped or truncated value. The accumulator instantiates it on the DONE path.

Test Plan (DATA_SIZE=16, REG_FILE_SIZE=8):
- Basic sum: no_z=2, no_p=1, terms {100, 50, 30}, sat_en=0, pulse start -> valid on edge 4, acc_pz=120 (0x0078), err=0, busy high for 4 cycles.
- Positive overflow: no_z=3, no_p=0, each term 0x7000.
  - sat_en=1 -> acc_pz=0x7FFF.
  - Repeat with sat_en=0 -> acc_pz=0x5000.
- Negative overflow: no_z=0, no_p=2, each term 0x7000.
  - sat_en=1 -> acc_pz=0x8000.
  - sat_en=0 -> acc_pz=0x2000.
  - Also check mixed-sign terms: z={-5}, p={-7} -> acc_pz=2.
- Empty and error cases:
  - no_z=0, no_p=0 -> valid after 1 edge, acc_pz=0, err=0.
  - Then no_z=5, no_p=4 -> valid after 1 edge, err=1, acc_pz still 0.
- Handshake robustness:
  - start held high continuously for no_z=1, no_p=1 -> back-to-back completions every 4 cycles.
  - Change flat_pz during RUN -> result uses the captured values.
- Reset mid-operation: drop rst_n on the 2nd RUN cycle of an 8-term operation -> outputs go to 0 immediately with no valid pulse. After release, a fresh start with {1,1,1} (no_z=3) -> acc_pz=3.
